// File: rtl/cp0_wb_sink.sv
// CP0 register file fed by the write-back stage's mtc0 triple: Count/Compare
// timer, Status/Cause/EPC bookkeeping for memory-stage exceptions, mfc0 read port.
module cp0_wb_sink #(
  parameter logic [31:0] PRID_VAL   = 32'h00480102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  localparam logic [31:0] STATUS_RST = 32'h10000000;
  // mtc0 may only touch IV, WP and the software interrupt bits IP[1:0].
  localparam logic [31:0] CAUSE_WMASK = 32'h00C00300;

  localparam logic [31:0] EXC_INT     = 32'h00000001;
  localparam logic [31:0] EXC_SYSCALL = 32'h00000008;
  localparam logic [31:0] EXC_RI      = 32'h0000000a;
  localparam logic [31:0] EXC_TRAP    = 32'h0000000d;
  localparam logic [31:0] EXC_OV      = 32'h0000000c;
  localparam logic [31:0] EXC_ERET    = 32'h0000000e;

  // Returns {recognised, ExcCode} for non-eret exception types.
  function automatic logic [5:0] exc_decode(input logic [31:0] t);
    logic [5:0] r;
    r = 6'd0;
    case (t)
      EXC_INT:     r = {1'b1, 5'd0};
      EXC_SYSCALL: r = {1'b1, 5'd8};
      EXC_RI:      r = {1'b1, 5'd10};
      EXC_TRAP:    r = {1'b1, 5'd13};
      EXC_OV:      r = {1'b1, 5'd12};
      default:     r = 6'd0;
    endcase
    return r;
  endfunction

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic        timer_q,   timer_d;

  logic        wr_count, wr_compare, wr_status, wr_cause, wr_epc;
  logic [5:0]  exc_info;
  logic        exc_take, exc_eret;

  always_comb begin
    wr_count   = we_i && (waddr_i == REG_COUNT);
    wr_compare = we_i && (waddr_i == REG_COMPARE);
    wr_status  = we_i && (waddr_i == REG_STATUS);
    wr_cause   = we_i && (waddr_i == REG_CAUSE);
    wr_epc     = we_i && (waddr_i == REG_EPC);
    exc_info   = exc_decode(excepttype_i);
    exc_take   = exc_info[5];
    exc_eret   = (excepttype_i == EXC_ERET);
  end

  always_comb begin
    count_d   = wr_count ? data_i : count_q + 32'd1;
    compare_d = compare_q;
    timer_d   = timer_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;

    // A Compare write acknowledges the timer even if a match occurs this cycle.
    if (wr_compare) begin
      compare_d = data_i;
      timer_d   = 1'b0;
    end else if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end

    if (wr_status) status_d = data_i;
    if (wr_epc)    epc_d    = data_i;
    if (wr_cause)  cause_d  = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    cause_d[15:10] = int_i;

    // Exception updates are layered on top of the mtc0 result.
    if (exc_take) begin
      if (!status_q[1]) begin
        if (is_in_delayslot_i) begin
          epc_d       = current_inst_addr_i - 32'd4;
          cause_d[31] = 1'b1;
        end else begin
          epc_d       = current_inst_addr_i;
          cause_d[31] = 1'b0;
        end
      end
      status_d[1]   = 1'b1;
      cause_d[6:2]  = exc_info[4:0];
    end else if (exc_eret) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RST;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_COUNT:   data_o = count_q;
      REG_COMPARE: data_o = compare_q;
      REG_STATUS:  data_o = status_q;
      REG_CAUSE:   data_o = cause_q;
      REG_EPC:     data_o = epc_q;
      REG_PRID:    data_o = PRID_VAL;
      REG_CONFIG:  data_o = CONFIG_VAL;
      default:     data_o = 32'd0;
    endcase
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_wb_sink.sv
// Directed bench for cp0_wb_sink: a spec-level model checked every cycle plus literal pins.
module tb_cp0_wb_sink;
  localparam logic [31:0] PRID_VAL   = 32'h00480102;
  localparam logic [31:0] CONFIG_VAL = 32'h00008000;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int total = 0;
  int bad   = 0;

  cp0_wb_sink #(.PRID_VAL(PRID_VAL), .CONFIG_VAL(CONFIG_VAL)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: register contents described field by field.
  logic        m_valid = 1'b0;
  logic [31:0] m_count, m_compare, m_status, m_epc;
  logic        m_bd, m_iv, m_wp, m_tmr;
  logic [1:0]  m_ipsw;
  logic [5:0]  m_iphw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_cause();
    return {m_bd, 7'd0, m_iv, m_wp, 6'd0, m_iphw, m_ipsw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      5'd16:   return CONFIG_VAL;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [31:0] cnt, cmp, st, epc;
    logic        bd, iv, wp, tmr, taken;
    logic [1:0]  ipsw;
    logic [4:0]  code;
    if (!rst) begin
      m_valid <= 1'b1;
      m_count <= 0; m_compare <= 0; m_status <= 32'h10000000; m_epc <= 0;
      m_bd <= 0; m_iv <= 0; m_wp <= 0; m_tmr <= 0; m_ipsw <= 0; m_iphw <= 0; m_exc <= 0;
    end else if (m_valid) begin
      cnt = m_count + 1; cmp = m_compare; st = m_status; epc = m_epc;
      bd = m_bd; iv = m_iv; wp = m_wp; ipsw = m_ipsw; tmr = m_tmr;
      if (m_compare != 0 && m_count == m_compare) tmr = 1'b1;
      if (we_i) begin
        if (waddr_i == 9)  cnt = data_i;
        if (waddr_i == 11) begin cmp = data_i; tmr = 1'b0; end
        if (waddr_i == 12) st = data_i;
        if (waddr_i == 14) epc = data_i;
        if (waddr_i == 13) begin iv = data_i[23]; wp = data_i[22]; ipsw = data_i[9:8]; end
      end
      taken = 1'b1; code = m_exc;
      case (excepttype_i)
        32'h1: code = 0;
        32'h8: code = 8;
        32'ha: code = 10;
        32'hd: code = 13;
        32'hc: code = 12;
        default: taken = 1'b0;
      endcase
      if (taken) begin
        if (m_status[1] == 1'b0) begin
          epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
          bd  = is_in_delayslot_i;
        end
        st[1] = 1'b1;
      end else if (excepttype_i == 32'he) begin
        st[1] = 1'b0;
      end
      m_count <= cnt; m_compare <= cmp; m_status <= st; m_epc <= epc;
      m_bd <= bd; m_iv <= iv; m_wp <= wp; m_ipsw <= ipsw; m_iphw <= int_i;
      m_exc <= code; m_tmr <= tmr;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("count",   count_o,   m_count);
      chk("compare", compare_o, m_compare);
      chk("status",  status_o,  m_status);
      chk("cause",   cause_o,   m_cause());
      chk("epc",     epc_o,     m_epc);
      chk("config",  config_o,  CONFIG_VAL);
      chk("prid",    prid_o,    PRID_VAL);
      chk("timer",   {31'd0, timer_int_o}, {31'd0, m_tmr});
      chk("data_o",  data_o,    m_read(raddr_i));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; data_i = d;
    step();
    we_i = 1'b0;
  endtask

  task automatic wait_count(input logic [31:0] target);
    for (int i = 0; i < 200; i++) begin
      if (count_o == target) break;
      step();
    end
    chk("wait_count", count_o, target);
  endtask

  initial begin
    rst = 1'b0; we_i = 0; waddr_i = 0; data_i = 0; raddr_i = 5'd15; int_i = 0;
    excepttype_i = 0; current_inst_addr_i = 0; is_in_delayslot_i = 0;
    step(); step();
    rst = 1'b1;
    repeat (5) step();
    chk("free_count", count_o, 32'd5);
    chk("rst_status", status_o, 32'h10000000);
    chk("prid_read", data_o, PRID_VAL);
    chk("rst_timer", {31'd0, timer_int_o}, 32'd0);

    // Timer: sticky until Compare is rewritten.
    raddr_i = 5'd11;
    mtc0(5'd11, 32'd20);
    wait_count(32'd20);
    chk("timer_at_match", {31'd0, timer_int_o}, 32'd0);
    step();
    chk("timer_rise", {31'd0, timer_int_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("timer_hold", {31'd0, timer_int_o}, 32'd1);
    end
    mtc0(5'd11, 32'd100);
    chk("timer_clear", {31'd0, timer_int_o}, 32'd0);
    chk("compare_100", compare_o, 32'd100);

    // Cause: only IV/WP/IP[1:0] writable, IP[7:2] track int_i.
    raddr_i = 5'd13;
    int_i = 6'b101010;
    mtc0(5'd13, 32'hFFFFFFFF);
    chk("cause_write", cause_o, 32'h00C0AB00);

    // Exceptions.
    raddr_i = 5'd14;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h100; is_in_delayslot_i = 1;
    step();
    chk("sys_epc", epc_o, 32'hFC);
    chk("sys_bd", {31'd0, cause_o[31]}, 32'd1);
    chk("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
    chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
    chk("sys_cause", cause_o, 32'h80C0AB20);
    excepttype_i = 32'hc; current_inst_addr_i = 32'h200; is_in_delayslot_i = 0;
    step();
    chk("ov_epc_held", epc_o, 32'hFC);
    chk("ov_code", {27'd0, cause_o[6:2]}, 32'd12);
    chk("ov_bd_held", {31'd0, cause_o[31]}, 32'd1);
    excepttype_i = 32'he;
    step();
    excepttype_i = 32'h0;
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
    chk("eret_status", status_o, 32'h10000000);

    // Count wrap.
    raddr_i = 5'd9;
    mtc0(5'd9, 32'hFFFFFFFE);
    chk("wrap0", count_o, 32'hFFFFFFFE);
    step(); chk("wrap1", count_o, 32'hFFFFFFFF);
    step(); chk("wrap2", count_o, 32'h0);
    step(); chk("wrap3", count_o, 32'h1);

    // Status write coinciding with syscall: exception sets EXL on top.
    raddr_i = 5'd12;
    excepttype_i = 32'h8; current_inst_addr_i = 32'h300;
    mtc0(5'd12, 32'h0);
    excepttype_i = 32'h0;
    chk("st_plus_exc", status_o, 32'h00000002);
    chk("st_exc_epc", epc_o, 32'h300);

    // Ignored writes and unmapped read.
    mtc0(5'd15, 32'h0);
    mtc0(5'd16, 32'h0);
    chk("prid_ro", prid_o, PRID_VAL);
    chk("config_ro", config_o, CONFIG_VAL);
    raddr_i = 5'd20;
    step();
    chk("unmapped", data_o, 32'h0);

    // Compare write on the match cycle: clear wins.
    mtc0(5'd9, 32'd55);
    mtc0(5'd11, 32'd60);
    wait_count(32'd60);
    mtc0(5'd11, 32'd200);
    chk("clear_wins", {31'd0, timer_int_o}, 32'd0);

    // Reset mid-sequence overrides a concurrent write.
    rst = 1'b0; we_i = 1; waddr_i = 5'd9; data_i = 32'h1234; excepttype_i = 32'h8;
    step();
    chk("mid_count", count_o, 32'h0);
    chk("mid_status", status_o, 32'h10000000);
    chk("mid_cause", cause_o, 32'h0);
    chk("mid_epc", epc_o, 32'h0);
    chk("mid_compare", compare_o, 32'h0);
    rst = 1'b1; we_i = 0; excepttype_i = 0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
